// File: rtl/fifo_ram_ctrl.sv
// Synchronous FIFO controller driving the write and read ports of a dual-port RAM.
// Owns the pointers, occupancy count, status flags, sticky error flags and the registered pop data.
module fifo_ram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clear_err,
    output logic [ADDR_WIDTH-1:0] ram_address_0,
    output logic                  ram_chip_enable_0,
    output logic                  ram_write_read_0,
    output logic [DATA_WIDTH-1:0] ram_data_0,
    output logic [ADDR_WIDTH-1:0] ram_address_1,
    output logic                  ram_chip_enable_1,
    output logic                  ram_write_read_1,
    input  logic [DATA_WIDTH-1:0] ram_data_1,
    output logic                  ram_full,
    output logic [1:0]            state_dbg
);

    // Handshake: push and pop are requests sampled on the rising edge. A request is
    // accepted only when the start-of-cycle flags allow it (push needs !full, pop needs
    // !empty) and flush is low; rejected requests leave no trace except the sticky
    // overflow/underflow flag. An accepted pop returns data with pop_valid one cycle later.

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] LAST_CNT  = DEPTH_CNT - 1'b1;
    localparam logic [ADDR_WIDTH:0] ONE_CNT   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] AF_CNT    = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_CNT    = AE_LEVEL[ADDR_WIDTH:0];

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   wptr, wptr_nxt;
    logic [ADDR_WIDTH:0]   rptr, rptr_nxt;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  push_acc;
    logic                  pop_acc;
    logic                  ovf_set;
    logic                  udf_set;

    assign full      = (state == ST_FULL);
    assign empty     = (state == ST_EMPTY);
    assign ram_full  = full;
    assign state_dbg = state;

    // rst gating keeps the RAM enables low while reset is held, not just after an edge.
    assign push_acc = push & ~full  & ~flush & ~rst;
    assign pop_acc  = pop  & ~empty & ~flush & ~rst;
    assign ovf_set  = push & full  & ~flush;
    assign udf_set  = pop  & empty & ~flush;

    assign ram_chip_enable_0 = push_acc;
    assign ram_address_0     = wptr[ADDR_WIDTH-1:0];
    assign ram_data_0        = push_data;
    assign ram_write_read_0  = 1'b1;
    assign ram_chip_enable_1 = pop_acc;
    assign ram_address_1     = rptr[ADDR_WIDTH-1:0];
    assign ram_write_read_1  = 1'b0;

    always_comb begin
        wptr_nxt  = wptr;
        rptr_nxt  = rptr;
        count_nxt = count;
        state_nxt = state;
        if (flush) begin
            wptr_nxt  = '0;
            rptr_nxt  = '0;
            count_nxt = '0;
            state_nxt = ST_EMPTY;
        end else begin
            if (push_acc) wptr_nxt = wptr + 1'b1;
            if (pop_acc)  rptr_nxt = rptr + 1'b1;
            case ({push_acc, pop_acc})
                2'b10:   count_nxt = count + 1'b1;
                2'b01:   count_nxt = count - 1'b1;
                default: count_nxt = count;
            endcase
            case (state)
                ST_EMPTY: begin
                    if (push_acc && !pop_acc) state_nxt = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (pop_acc && !push_acc && count == ONE_CNT)
                        state_nxt = ST_EMPTY;
                    else if (push_acc && !pop_acc && count == LAST_CNT)
                        state_nxt = ST_FULL;
                end
                ST_FULL: begin
                    if (pop_acc) state_nxt = ST_ACTIVE;
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_EMPTY;
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            pop_valid    <= 1'b0;
            pop_data     <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            state        <= state_nxt;
            wptr         <= wptr_nxt;
            rptr         <= rptr_nxt;
            count        <= count_nxt;
            // Flags follow the next count so they line up with count itself.
            almost_full  <= (count_nxt >= AF_CNT);
            almost_empty <= (count_nxt <= AE_CNT);
            pop_valid    <= pop_acc;
            if (pop_acc) pop_data <= ram_data_1;
            overflow     <= ovf_set | (overflow  & ~clear_err);
            underflow    <= udf_set | (underflow & ~clear_err);
        end
    end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Randomized scoreboard bench for fifo_ram_ctrl with a small RAM model and a queue-based
// reference FIFO; a negedge monitor checks every pop_valid beat against the expected queue.
module tb_fifo_ram_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          push;
    logic [DW-1:0] push_data;
    logic          pop;
    logic          clear_err;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic [AW-1:0] ram_address_0;
    logic          ram_chip_enable_0;
    logic          ram_write_read_0;
    logic [DW-1:0] ram_data_0;
    logic [AW-1:0] ram_address_1;
    logic          ram_chip_enable_1;
    logic          ram_write_read_1;
    logic [DW-1:0] ram_data_1;
    logic          ram_full;
    logic [1:0]    state_dbg;

    fifo_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .push_data(push_data),
        .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow),
        .clear_err(clear_err), .ram_address_0(ram_address_0),
        .ram_chip_enable_0(ram_chip_enable_0), .ram_write_read_0(ram_write_read_0),
        .ram_data_0(ram_data_0), .ram_address_1(ram_address_1),
        .ram_chip_enable_1(ram_chip_enable_1), .ram_write_read_1(ram_write_read_1),
        .ram_data_1(ram_data_1), .ram_full(ram_full), .state_dbg(state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // dual-port RAM model: synchronous write, combinational read
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) if (ram_chip_enable_0) mem[ram_address_0] <= ram_data_0;
    assign ram_data_1 = mem[ram_address_1];

    // reference model and scoreboard
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    bit m_ovf, m_udf, m_pv;
    int wr_pos, rd_pos;
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_ovf = 0; m_udf = 0; m_pv = 0;
        wr_pos = 0; rd_pos = 0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".count"}, count, mq.size());
        chk({tag, ".full"}, full, mq.size() == DEPTH);
        chk({tag, ".ram_full"}, ram_full, mq.size() == DEPTH);
        chk({tag, ".empty"}, empty, mq.size() == 0);
        chk({tag, ".almost_full"}, almost_full, mq.size() >= DEPTH - 2);
        chk({tag, ".almost_empty"}, almost_empty, mq.size() <= 2);
        chk({tag, ".overflow"}, overflow, m_ovf);
        chk({tag, ".underflow"}, underflow, m_udf);
        chk({tag, ".pop_valid"}, pop_valid, m_pv);
    endtask

    // driver: one clock cycle of stimulus, called just after a falling edge
    task automatic cyc(input bit p, input logic [DW-1:0] d, input bit q, input bit f,
                       input bit c, input string tag);
        bit pa, qa, fullm, emptym;
        push = p; push_data = d; pop = q; flush = f; clear_err = c;
        fullm  = (mq.size() == DEPTH);
        emptym = (mq.size() == 0);
        pa = p && !fullm && !f;
        qa = q && !emptym && !f;
        #1;
        chk({tag, ".ce0"}, ram_chip_enable_0, pa);
        chk({tag, ".ce1"}, ram_chip_enable_1, qa);
        chk({tag, ".wr0"}, ram_write_read_0, 1);
        chk({tag, ".wr1"}, ram_write_read_1, 0);
        if (pa) begin
            chk({tag, ".addr0"}, ram_address_0, wr_pos);
            chk({tag, ".wdata"}, ram_data_0, d);
        end
        if (qa) chk({tag, ".addr1"}, ram_address_1, rd_pos);
        m_ovf = (p && fullm && !f) || (m_ovf && !c);
        m_udf = (q && emptym && !f) || (m_udf && !c);
        if (f) begin
            mq.delete();
            wr_pos = 0;
            rd_pos = 0;
        end else begin
            if (qa) begin
                exp_q.push_back(mq.pop_front());
                rd_pos = (rd_pos + 1) % DEPTH;
            end
            if (pa) begin
                mq.push_back(d);
                wr_pos = (wr_pos + 1) % DEPTH;
            end
        end
        m_pv = qa;
        @(posedge clk);
        @(negedge clk);
        chk_state(tag);
    endtask

    task automatic idle(input string tag);
        cyc(0, '0, 0, 0, 0, tag);
    endtask

    // monitor: every presented pop beat is matched against the expected queue
    always @(negedge clk) begin
        if (!rst && pop_valid) begin
            if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
            else chk("pop_data", pop_data, exp_q.pop_front());
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        rst = 1'b1; flush = 0; push = 0; push_data = '0; pop = 0; clear_err = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_state("reset");
        chk("reset.pop_data", pop_data, 0);
        chk("reset.ce0", ram_chip_enable_0, 0);
        chk("reset.ce1", ram_chip_enable_1, 0);
        rst = 1'b0;
        @(negedge clk);

        // fill to full, then overflow and clear
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'(8'h11 + i), 0, 0, 0, "fill");
        cyc(1, 8'h99, 0, 0, 0, "overflow");
        cyc(0, '0, 0, 0, 1, "clr_ovf");

        // drain, then underflow and clear
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, '0, 1, 0, 0, "drain");
        cyc(0, '0, 0, 0, 1, "clr_udf");

        // steady count of 3 with simultaneous push+pop across pointer wrap
        for (int i = 0; i < 3; i++) cyc(1, 8'($urandom_range(0, 255)), 0, 0, 0, "pre3");
        for (int i = 0; i < 20; i++) cyc(1, 8'($urandom_range(0, 255)), 1, 0, 0, "wrap");
        for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, 0, "post3");
        idle("idle1");

        // push+pop while empty: no bypass
        cyc(1, 8'h5a, 1, 0, 0, "empty_pp");
        cyc(0, '0, 1, 0, 1, "empty_pp_pop");
        idle("idle2");

        // flush with push at count 5
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h30 + i), 0, 0, 0, "pre_flush");
        cyc(1, 8'h77, 0, 1, 0, "flush_push");
        idle("post_flush");

        // randomized traffic
        for (int i = 0; i < 400; i++)
            cyc(bit'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                bit'($urandom_range(0, 1)), $urandom_range(0, 24) == 0,
                $urandom_range(0, 9) == 0, "rand");

        // asynchronous reset in the middle of a burst
        cyc(0, '0, 0, 1, 0, "pre_rst_flush");
        for (int i = 0; i < DEPTH + 1; i++) cyc(1, 8'(8'hA0 + i), 0, 0, 0, "pre_rst_fill");
        cyc(0, '0, 1, 0, 0, "pre_rst_pop");
        #2;
        push = 1'b1; push_data = 8'hEE; pop = 1'b1;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst.count", count, 0);
        chk("arst.empty", empty, 1);
        chk("arst.almost_empty", almost_empty, 1);
        chk("arst.full", full, 0);
        chk("arst.almost_full", almost_full, 0);
        chk("arst.pop_valid", pop_valid, 0);
        chk("arst.pop_data", pop_data, 0);
        chk("arst.overflow", overflow, 0);
        chk("arst.underflow", underflow, 0);
        chk("arst.ce0", ram_chip_enable_0, 0);
        chk("arst.ce1", ram_chip_enable_1, 0);
        @(posedge clk);
        @(negedge clk);
        chk_state("arst_hold");
        rst = 1'b0;
        for (int i = 0; i < 40; i++)
            cyc(bit'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                bit'($urandom_range(0, 1)), 0, 0, "post_rst");
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, '0, 1, 0, 0, "final_drain");
        idle("final");
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
